// File: rtl/simd_warp_sequencer.sv
// Single-warp SIMD sequencer: fetches, issues and load-stalls one kernel, then drains lanes.
// Define SIMD_PERF_CNT_EN to build the saturating performance counters; otherwise they read 0.
module simd_warp_sequencer #(
    parameter int unsigned THREAD_COUNT = 8,
    parameter int unsigned WARP_ID_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    kernel_valid,
    output logic                    kernel_ready,
    input  logic [31:0]             kernel_start_pc,
    input  logic [WARP_ID_W-1:0]    kernel_warp_id,
    input  logic [THREAD_COUNT-1:0] kernel_mask,
    output logic                    imem_req,
    output logic [31:0]             imem_addr,
    input  logic                    imem_valid,
    input  logic [31:0]             imem_rdata,
    output logic                    dmem_req,
    output logic [31:0]             dmem_addr,
    input  logic                    dmem_valid,
    output logic                    issue_valid,
    output logic [31:0]             issue_instr,
    output logic [THREAD_COUNT-1:0] issue_mask,
    input  logic [THREAD_COUNT-1:0] thread_done,
    output logic                    busy,
    output logic                    done_pulse,
    output logic [WARP_ID_W-1:0]    done_warp_id,
    output logic [31:0]             perf_cycles,
    output logic [31:0]             perf_instrs,
    output logic [31:0]             perf_stalls
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitI,
        StIssue,
        StLoad,
        StDrain,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [31:0]             pc_q, pc_d;
    logic [31:0]             instr_q, instr_d;
    logic [THREAD_COUNT-1:0] mask_q, mask_d;
    logic [WARP_ID_W-1:0]    warp_id_q, warp_id_d;
    logic                    accept;

    assign accept = kernel_valid && (state_q == StIdle);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        mask_d    = mask_q;
        warp_id_d = warp_id_q;
        case (state_q)
            StIdle: begin
                if (kernel_valid) begin
                    pc_d      = kernel_start_pc;
                    mask_d    = kernel_mask;
                    warp_id_d = kernel_warp_id;
                    state_d   = (kernel_mask == '0) ? StDone : StFetch;
                end
            end
            StFetch: state_d = StWaitI;
            StWaitI: begin
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                case (instr_q[31:29])
                    3'b111:  state_d = StDrain;
                    3'b110:  state_d = StLoad;
                    default: begin
                        pc_d    = pc_q + 32'd4;
                        state_d = StFetch;
                    end
                endcase
            end
            StLoad: begin
                if (dmem_valid) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = StFetch;
                end
            end
            StDrain: begin
                // Masked-off lanes never block completion.
                if ((thread_done & mask_q) == mask_q) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            instr_q   <= '0;
            mask_q    <= '0;
            warp_id_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            mask_q    <= mask_d;
            warp_id_q <= warp_id_d;
        end
    end

    always_comb begin
        kernel_ready = (state_q == StIdle);
        busy         = (state_q != StIdle);
        imem_req     = (state_q == StFetch) || (state_q == StWaitI);
        imem_addr    = imem_req ? pc_q : '0;
        dmem_req     = (state_q == StLoad);
        dmem_addr    = dmem_req ? {23'b0, instr_q[8:0]} : '0;
        issue_valid  = (state_q == StIssue) && (instr_q[31:29] != 3'b111);
        issue_instr  = instr_q;
        issue_mask   = mask_q;
        done_pulse   = (state_q == StDone);
        done_warp_id = done_pulse ? warp_id_q : '1;
    end

`ifdef SIMD_PERF_CNT_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_instrs_q, perf_instrs_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;
    logic        stall;

    assign stall = (state_q == StWaitI) || (state_q == StLoad);

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_instrs_d = perf_instrs_q;
        perf_stalls_d = perf_stalls_q;
        if (accept) begin
            perf_cycles_d = '0;
            perf_instrs_d = '0;
            perf_stalls_d = '0;
        end else begin
            if (busy && (perf_cycles_q != '1))        perf_cycles_d = perf_cycles_q + 32'd1;
            if (issue_valid && (perf_instrs_q != '1)) perf_instrs_d = perf_instrs_q + 32'd1;
            if (stall && (perf_stalls_q != '1))       perf_stalls_d = perf_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_instrs_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_instrs_q <= perf_instrs_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_instrs = perf_instrs_q;
    assign perf_stalls = perf_stalls_q;
`else
    assign perf_cycles = '0;
    assign perf_instrs = '0;
    assign perf_stalls = '0;
`endif

endmodule
